// File: rtl/conv2d_stream_engine.sv
// Single-channel 2D convolution, valid padding, stride 1. One MAC per cycle,
// results streamed in raster order over valid/ready with shift/saturate/ReLU.
module conv2d_stream_engine #(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = 20,
  parameter int SHIFT = 0,
  parameter int AW    = $clog2((IMG_W*IMG_H > K*K) ? IMG_W*IMG_H : K*K),
  localparam int OUT_W = IMG_W - K + 1,
  localparam int OUT_H = IMG_H - K + 1,
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          start,
  input  logic          relu_en,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pixel,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NTAP = K * K;
  localparam int IAW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int KAW  = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int KCW  = (K > 1) ? $clog2(K) : 1;
  localparam logic [KCW-1:0] KMAX = KCW'(K - 1);
  localparam logic [RW-1:0]  RMAX = RW'(OUT_H - 1);
  localparam logic [CW-1:0]  CMAX = CW'(OUT_W - 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2**(DW-1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic signed [ACC_W-1:0] UMAX = ACC_W'(2**DW - 1);

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;
  state_t state, nxt;

  logic [DW-1:0]        img_mem [NPIX];
  logic signed [DW-1:0] ker_mem [NTAP];
  logic [KCW-1:0]       kx, ky;
  logic [RW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic signed [ACC_W-1:0] acc, prod, sum;
  logic signed [DW:0]   pix_s;
  logic [IAW-1:0]       img_idx;
  logic [KAW-1:0]       ker_idx;
  logic                 relu_q, tap_last, win_last;

  function automatic logic [DW-1:0] post(input logic signed [ACC_W-1:0] s, input logic relu);
    logic signed [ACC_W-1:0] t;
    t = s >>> SHIFT;
    if (relu) begin
      if (t < 0)         return '0;
      else if (t > UMAX) return '1;
      else               return t[DW-1:0];
    end else begin
      if (t > SMAX)      return SMAX[DW-1:0];
      else if (t < SMIN) return SMIN[DW-1:0];
      else               return t[DW-1:0];
    end
  endfunction

  // Memories have no reset so contents survive an aborted run.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      if (!cfg_sel && int'(cfg_addr) < NPIX) img_mem[cfg_addr[IAW-1:0]] <= cfg_data;
      if (cfg_sel && int'(cfg_addr) < NTAP)  ker_mem[cfg_addr[KAW-1:0]] <= cfg_data;
    end
  end

  assign img_idx  = IAW'((int'(row_q) + int'(ky)) * IMG_W + int'(col_q) + int'(kx));
  assign ker_idx  = KAW'(int'(ky) * K + int'(kx));
  assign pix_s    = signed'({1'b0, img_mem[img_idx]});
  assign prod     = ACC_W'(pix_s) * ACC_W'(ker_mem[ker_idx]);
  assign sum      = acc + prod;
  assign tap_last = (kx == KMAX) && (ky == KMAX);
  assign win_last = (row_q == RMAX) && (col_q == CMAX);
  assign out_row  = row_q;
  assign out_col  = col_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = MAC;
      MAC:     if (tap_last) nxt = EMIT;
      EMIT:    if (out_ready) nxt = win_last ? DONE : MAC;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == MAC) || (state == EMIT);
    out_valid = (state == EMIT);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0; kx <= '0; ky <= '0; row_q <= '0; col_q <= '0;
      out_pixel <= '0; relu_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          relu_q <= relu_en; acc <= '0; kx <= '0; ky <= '0;
          row_q <= '0; col_q <= '0;
        end
        MAC: begin
          kx <= (kx == KMAX) ? '0 : kx + KCW'(1);
          if (kx == KMAX) ky <= (ky == KMAX) ? '0 : ky + KCW'(1);
          // Final tap folds straight into the output register.
          if (tap_last) out_pixel <= post(sum, relu_q);
          else          acc <= sum;
        end
        EMIT: if (out_ready && !win_last) begin
          acc <= '0;
          if (col_q == CMAX) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
